// File: rtl/mux4x1_stream_rr_if.sv
// Stream bundle between four producers, the round-robin merger and one consumer.
interface mux4x1_stream_rr_if #(
  parameter int unsigned WIDTH = 8
);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/mux4x1_stream_rr.sv
// Four-into-one stream merger with round-robin arbitration and a one-entry
// registered output stage; out_sel tags each beat with its source channel.
module mux4x1_stream_rr #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  mux4x1_stream_rr_if.slave   bus
);

  localparam int unsigned NCH = 4;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic [1:0]       last_grant_q, last_grant_d;

  logic       found;
  logic [1:0] winner;
  logic [1:0] idx;
  logic       can_accept;
  logic       take;

  // Round-robin search starting one past the last granted channel.
  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    idx    = 2'd0;
    for (int k = 1; k <= int'(NCH); k++) begin
      idx = last_grant_q + 2'(k);
      if (!found && bus.in_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Output slot is free when empty or being drained this cycle.
  assign can_accept = (state_q == EMPTY) | bus.out_ready;
  assign take       = found & can_accept & ~rst;

  always_comb begin
    bus.in_ready = 4'b0000;
    if (take) bus.in_ready = 4'(1) << winner;
  end

  always_comb begin
    state_d      = state_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    if (take) begin
      state_d      = FULL;
      out_sel_d    = winner;
      last_grant_d = winner;
      for (int i = 0; i < int'(NCH); i++) begin
        if (winner == 2'(i)) out_data_d = bus.in_data[i*WIDTH +: WIDTH];
      end
    end else if ((state_q == FULL) && bus.out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      out_data_q   <= '0;
      out_sel_q    <= 2'd0;
      last_grant_q <= 2'd3;
    end else begin
      state_q      <= state_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule
